// File: rtl/dram_req_bridge_pkg.sv
// Shared definitions for the SRAM-to-SRAM-like request bridges (data and instruction side):
// FSM state encoding, transfer size codes and the byte-select to size decode.
package dram_req_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } bridge_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Unrecognised lane patterns (including all-zero on loads) fall back to a full word.
  function automatic logic [1:0] sel_to_size(input logic [3:0] sel);
    logic [1:0] size;
    case (sel)
      4'b1111:                            size = SIZE_WORD;
      4'b0011, 4'b1100:                   size = SIZE_HALF;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_BYTE;
      default:                            size = SIZE_WORD;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/dram_req_bridge.sv
// Converts single-cycle datapath memory accesses into one SRAM-like transaction each, one outstanding.
// Stall is combinational from ce and drops in the data_ok cycle; returned data is parked while stall_all_i holds the pipe.
module dram_req_bridge
  import dram_req_bridge_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_ram_ce_i,
  input  logic        cpu_ram_we_i,
  input  logic [31:0] cpu_ram_addr_i,
  input  logic [31:0] cpu_ram_wdata_i,
  input  logic [3:0]  cpu_ram_sel_i,
  input  logic        stall_all_i,
  output logic        cpu_ram_stall_o,
  output logic [31:0] cpu_ram_data_o,
  output logic        data_req_o,
  output logic        data_wr_o,
  output logic [1:0]  data_size_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  output logic [3:0]  data_wstrb_o,
  input  logic [31:0] data_rdata_i,
  input  logic        data_addr_ok_i,
  input  logic        data_data_ok_i
);

  bridge_state_t state_q, state_d;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  sel_q;
  logic [1:0]  size_q;
  logic [31:0] rdata_q;

  logic accept;
  logic complete;
  logic stall;

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;
    stall    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall = cpu_ram_ce_i;
        if (cpu_ram_ce_i) begin
          accept  = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (data_addr_ok_i) begin
          if (data_data_ok_i) complete = 1'b1;
          else                state_d  = ST_WAIT;
        end
        // A withdrawn ce lets the pipe move on; the transaction still drains.
        stall = cpu_ram_ce_i & ~complete;
      end
      ST_WAIT: begin
        complete = data_data_ok_i;
        stall    = cpu_ram_ce_i & ~complete;
      end
      ST_DONE: begin
        if (!stall_all_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (complete) state_d = stall_all_i ? ST_DONE : ST_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request fields are captured once and held until the transaction ends.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      sel_q   <= 4'h0;
      size_q  <= SIZE_BYTE;
    end else if (accept) begin
      we_q    <= cpu_ram_we_i;
      addr_q  <= cpu_ram_addr_i;
      wdata_q <= cpu_ram_wdata_i;
      sel_q   <= cpu_ram_sel_i;
      size_q  <= sel_to_size(cpu_ram_sel_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= 32'h0;
    end else if (complete) begin
      rdata_q <= data_rdata_i;
    end
  end

  assign cpu_ram_stall_o = stall;
  assign cpu_ram_data_o  = complete ? data_rdata_i : rdata_q;

  assign data_req_o   = (state_q == ST_REQ);
  assign data_wr_o    = we_q;
  assign data_size_o  = size_q;
  assign data_addr_o  = addr_q;
  assign data_wdata_o = wdata_q;
  assign data_wstrb_o = we_q ? sel_q : 4'h0;

endmodule

// File: tb/tb_dram_req_bridge.sv
// Directed bench for dram_req_bridge: inputs change on the falling edge, outputs checked 1ns later.
module tb_dram_req_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        stall_all;
  logic        stall;
  logic [31:0] ram_data;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dram_req_bridge dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .cpu_ram_ce_i    (ce),
    .cpu_ram_we_i    (we),
    .cpu_ram_addr_i  (addr),
    .cpu_ram_wdata_i (wdata),
    .cpu_ram_sel_i   (sel),
    .stall_all_i     (stall_all),
    .cpu_ram_stall_o (stall),
    .cpu_ram_data_o  (ram_data),
    .data_req_o      (req),
    .data_wr_o       (wr),
    .data_size_o     (size),
    .data_addr_o     (req_addr),
    .data_wdata_o    (req_wdata),
    .data_wstrb_o    (wstrb),
    .data_rdata_i    (rdata),
    .data_addr_ok_i  (addr_ok),
    .data_data_ok_i  (data_ok)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One access acknowledged with addr_ok+data_ok on its first req cycle, then one quiet cycle.
  task automatic quick_xact(input string tag, input logic w, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] s,
                            input logic [31:0] rd, input logic [1:0] exp_size);
    @(negedge clk);
    ce = 1'b1; we = w; addr = a; wdata = wd; sel = s;
    addr_ok = 1'b0; data_ok = 1'b0;
    #1 check({tag, "_stall_issue"}, 32'(stall), 32'd1);
    check({tag, "_req_issue"}, 32'(req), 32'd0);
    @(negedge clk);
    addr_ok = 1'b1; data_ok = 1'b1; rdata = rd;
    #1 check({tag, "_req"}, 32'(req), 32'd1);
    check({tag, "_size"}, 32'(size), 32'(exp_size));
    check({tag, "_wr"}, 32'(wr), 32'(w));
    check({tag, "_wstrb"}, 32'(wstrb), w ? 32'(s) : 32'd0);
    check({tag, "_addr"}, req_addr, a);
    check({tag, "_stall_done"}, 32'(stall), 32'd0);
    check({tag, "_data_ok_cycle"}, ram_data, rd);
    @(negedge clk);
    ce = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;
    #1 check({tag, "_req_after"}, 32'(req), 32'd0);
    check({tag, "_data_held"}, ram_data, rd);
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; we = 1'b0; addr = 32'h0; wdata = 32'h0; sel = 4'h0;
    stall_all = 1'b0; rdata = 32'hFFFF_FFFF; addr_ok = 1'b0; data_ok = 1'b0;

    // Reset values; stall follows ce even while in reset.
    #1 check("rst_stall", 32'(stall), 32'd1);
    check("rst_req", 32'(req), 32'd0);
    check("rst_size", 32'(size), 32'd0);
    check("rst_wstrb", 32'(wstrb), 32'd0);
    check("rst_wr", 32'(wr), 32'd0);
    check("rst_addr", req_addr, 32'h0);
    check("rst_data", ram_data, 32'h0);
    @(negedge clk);
    rst = 1'b0; ce = 1'b0; rdata = 32'h0;

    // Load hit: single stall cycle, data valid in the data_ok cycle.
    quick_xact("ld_hit", 1'b0, 32'h8000_0010, 32'h0, 4'b1111, 32'hDEAD_BEEF, 2'd2);

    // Store byte: addr_ok three cycles late, data_ok two cycles after that.
    @(negedge clk);
    ce = 1'b1; we = 1'b1; addr = 32'h1000_0002; wdata = 32'h00AB_0000; sel = 4'b0100;
    #1 check("st_stall_issue", 32'(stall), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      addr = 32'h9999_0000 + i; sel = 4'b1111; wdata = 32'h0;
      #1 check("st_req_hold", 32'(req), 32'd1);
      check("st_addr_hold", req_addr, 32'h1000_0002);
      check("st_stall_hold", 32'(stall), 32'd1);
    end
    check("st_size", 32'(size), 32'd0);
    check("st_wstrb", 32'(wstrb), 32'h4);
    check("st_wr", 32'(wr), 32'd1);
    check("st_wdata", req_wdata, 32'h00AB_0000);
    @(negedge clk);
    addr_ok = 1'b1;
    #1 check("st_req_ack", 32'(req), 32'd1);
    check("st_stall_ack", 32'(stall), 32'd1);
    @(negedge clk);
    addr_ok = 1'b0;
    #1 check("st_wait_req", 32'(req), 32'd0);
    check("st_wait_stall", 32'(stall), 32'd1);
    @(negedge clk);
    data_ok = 1'b1;
    #1 check("st_done_stall", 32'(stall), 32'd0);
    @(negedge clk);
    data_ok = 1'b0; ce = 1'b0; we = 1'b0;
    #1 check("st_idle_req", 32'(req), 32'd0);

    // Completion under global freeze: result parked through DONE.
    @(negedge clk);
    ce = 1'b1; addr = 32'h0000_2000; sel = 4'b1111;
    @(negedge clk);
    addr_ok = 1'b1;
    @(negedge clk);
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h1234_5678; stall_all = 1'b1;
    #1 check("frz_stall_cmp", 32'(stall), 32'd0);
    check("frz_data_cmp", ram_data, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data_ok = 1'b0; rdata = 32'hBAD0_0000 + i;
      #1 check("frz_done_data", ram_data, 32'h1234_5678);
      check("frz_done_req", 32'(req), 32'd0);
      check("frz_done_stall", 32'(stall), 32'd0);
    end
    @(negedge clk);
    stall_all = 1'b0;
    #1 check("frz_release_data", ram_data, 32'h1234_5678);
    check("frz_release_req", 32'(req), 32'd0);
    ce = 1'b0;

    // Size decode: halfword, illegal two-lane pattern, load with no lanes.
    quick_xact("half", 1'b1, 32'h0000_3002, 32'h5566_0000, 4'b1100, 32'h0, 2'd1);
    quick_xact("sel0110", 1'b1, 32'h0000_3004, 32'h0011_2200, 4'b0110, 32'h0, 2'd2);
    quick_xact("sel0000", 1'b0, 32'h0000_3008, 32'h0, 4'b0000, 32'hCAFE_F00D, 2'd2);

    // Reset in WAIT abandons the access.
    @(negedge clk);
    ce = 1'b1; we = 1'b0; addr = 32'h0000_4000; sel = 4'b1111;
    @(negedge clk);
    addr_ok = 1'b1;
    @(negedge clk);
    addr_ok = 1'b0;
    #1 check("rw_wait_data", ram_data, 32'hCAFE_F00D);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rw_req", 32'(req), 32'd0);
    check("rw_data", ram_data, 32'h0);
    check("rw_stall", 32'(stall), 32'd1);
    @(negedge clk);
    rst = 1'b0; ce = 1'b0;
    #1 check("rw_idle_stall", 32'(stall), 32'd0);
    quick_xact("rw_fresh", 1'b0, 32'h0000_5000, 32'h0, 4'b1111, 32'h0BAD_CAFE, 2'd2);

    // ce withdrawn while REQ is pending: the access drains, stall stays low.
    @(negedge clk);
    ce = 1'b1; addr = 32'h0000_6000; sel = 4'b0011;
    @(negedge clk);
    ce = 1'b0;
    #1 check("wd_req", 32'(req), 32'd1);
    check("wd_stall", 32'(stall), 32'd0);
    check("wd_size", 32'(size), 32'd1);
    @(negedge clk);
    addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h7777_0000;
    #1 check("wd_req_ack", 32'(req), 32'd1);
    check("wd_stall_ack", 32'(stall), 32'd0);
    @(negedge clk);
    addr_ok = 1'b0; data_ok = 1'b0; ce = 1'b1; addr = 32'h0000_7000; sel = 4'b1111;
    #1 check("wd_next_stall", 32'(stall), 32'd1);
    check("wd_next_req0", 32'(req), 32'd0);
    @(negedge clk);
    #1 check("wd_next_req", 32'(req), 32'd1);
    check("wd_next_addr", req_addr, 32'h0000_7000);
    addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h0;
    @(negedge clk);
    ce = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    #1 check("wd_end_req", 32'(req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dram_req_bridge.md
# dram_req_bridge

Data-side bridge between the datapath's SRAM-style memory port (ce/we/addr/wdata/sel plus a stall back-channel) and the cache's SRAM-like data port (req/wr/size/addr/wdata with addr_ok/data_ok). It turns each single-cycle CPU access into one SRAM-like transaction and holds the datapath stalled until data returns. It also parks the returned load data while the rest of the pipeline is frozen by the global stall. It sits between `datapath` and `cache` on the data path, alongside the instruction-side bridge.

## Interface
- No parameters; widths fixed at 32-bit address/data, 4-bit byte select.
- `clk_i` in 1: the single clock; all state changes on its rising edge.
- `rst_i` in 1: reset, asynchronous and active-high.
- `cpu_ram_ce_i` in 1: access request from MEM stage.
- `cpu_ram_we_i` in 1: 1 = store, 0 = load.
- `cpu_ram_addr_i` in 32: byte address.
- `cpu_ram_wdata_i` in 32: store data, already lane-aligned.
- `cpu_ram_sel_i` in 4: byte-lane select.
- `stall_all_i` in 1: global pipeline freeze from datapath.
- `cpu_ram_stall_o` out 1: hold MEM stage.
- `cpu_ram_data_o` out 32: load result.
- `data_req_o` out 1: SRAM-like request.
- `data_wr_o` out 1: request is a write.
- `data_size_o` out 2: 0 = byte, 1 = half, 2 = word.
- `data_addr_o` out 32: request address.
- `data_wdata_o` out 32: request write data.
- `data_wstrb_o` out 4: byte strobes (= latched sel for writes, 0 for reads).
- `data_rdata_i` in 32: read data, valid with data_ok.
- `data_addr_ok_i` in 1: request accepted.
- `data_data_ok_i` in 1: transaction complete.

## Operation
- FSM states: IDLE, REQ (req high, awaiting addr_ok), WAIT (awaiting data_ok), DONE (result held, awaiting stall_all_i low).
- IDLE:
  - With ce=1, register we/addr/wdata/sel into request regs. Go to REQ.
  - `cpu_ram_stall_o` = ce (combinational) so MEM holds from the first cycle.
- REQ:
  - `data_req_o`=1, with fields from request regs.
  - addr_ok=1 without data_ok: go to WAIT.
  - addr_ok=1 with data_ok in the same cycle: completion, handled as below.
- WAIT: req=0. On data_ok, completion.
- Completion:
  - Latch `data_rdata_i` into rdata_q; stall_o=0 in that same cycle.
  - stall_all_i=0: go to IDLE.
  - stall_all_i=1: go to DONE.
- DONE: stall_o=0, no new request issued. Go to IDLE when stall_all_i=0.
- `cpu_ram_data_o` = data_rdata_i in the data_ok cycle, rdata_q otherwise.
- Size from sel:
  - 1111 → 2.
  - 0011/1100 → 1.
  - one-hot → 0.
  - any other value, including 0000 on loads → 2.
- `data_addr_o` passes the byte address unmodified.
- ce dropping while in REQ/WAIT does not cancel the transaction: it completes and its data is discarded; stall_o follows ce.
- Exactly one outstanding transaction; no new ce is sampled until back in IDLE.

## Timing
- Reset (async, immediate):
  - State → IDLE; request regs and rdata_q → 0.
  - data_req_o=0, data_wr_o=0, data_size_o=0, data_addr_o=0, data_wdata_o=0, data_wstrb_o=0.
  - cpu_ram_data_o=0; cpu_ram_stall_o = cpu_ram_ce_i.
- Reset mid-transaction abandons it; the cache shares `rst_i`.
- Minimum load latency: ce at cycle 0 → req at cycle 1 → addr_ok+data_ok at cycle 1 → stall_o low and data valid at cycle 1.
- Each additional cycle of addr_ok or data_ok delay adds one stall cycle.
- req is held stable (all fields constant) from assertion until addr_ok.
- rdata_q stays stable throughout DONE.

## Structure
- Shared package: FSM state enum, size encodings (SIZE_BYTE/HALF/WORD), `sel_to_size` function (reused by the instruction bridge).
- Single module; no sub-module needed.

## Test plan
- Load hit: ce=1, we=0, addr=0x8000_0010, sel=1111; addr_ok+data_ok at first req cycle with rdata=0xDEAD_BEEF → stall high one cycle, size=2, data_o=0xDEAD_BEEF.
- Store byte with delayed handshake: sel=0100, wdata=0x00AB_0000; addr_ok 3 cycles after req, data_ok 2 later → size=0, wstrb=0100, wr=1, req held 4 cycles, stall released on data_ok.
- Freeze after completion: data_ok with rdata=0x1234_5678 while stall_all_i=1 for 4 cycles → DONE, data_o stays 0x1234_5678, no req, return to IDLE after release.
- Halfword/illegal sel: sel=1100 → size=1; sel=0110 → size=2; load with sel=0000 → size=2, wstrb=0000.
- Reset mid-WAIT: assert rst_i between addr_ok and data_ok → req=0, data_o=0, state IDLE immediately; next ce issues a fresh request.
- ce withdrawn in REQ: drop ce before addr_ok → req continues to addr_ok/data_ok, stall_o=0, FSM returns to IDLE, next ce accepted.
